// File: rtl/obi_sram_bridge.sv
// Two-manager OBI-to-SRAM bridge: round-robin arbitration of the instr (read-only) and
// data (read/write) OBI ports onto one single-port RAM, with a 1-deep response pipe.
module obi_sram_bridge #(
    parameter int unsigned                SOC_ADDR_WIDTH = 32,
    parameter int unsigned                RAM_ADDR_WIDTH = 10,
    parameter logic [SOC_ADDR_WIDTH-1:0]  RAM_BASE       = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    // instr OBI (read-only)
    input  logic                      instr_req_i,
    output logic                      instr_gnt_o,
    input  logic [SOC_ADDR_WIDTH-1:0] instr_addr_i,
    output logic                      instr_rvalid_o,
    output logic [31:0]               instr_rdata_o,
    output logic                      instr_err_o,
    // data OBI
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    input  logic [SOC_ADDR_WIDTH-1:0] data_addr_i,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [31:0]               data_wdata_i,
    output logic                      data_rvalid_o,
    output logic [31:0]               data_rdata_o,
    output logic                      data_err_o,
    // RAM port
    output logic                      ram_en_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]               ram_wdata_o,
    output logic                      ram_we_o,
    output logic [3:0]                ram_be_o,
    input  logic [31:0]               ram_rdata_i
);

    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;
    localparam logic [SOC_ADDR_WIDTH:0] RAM_BYTES =
        (SOC_ADDR_WIDTH+1)'(1) << (RAM_ADDR_WIDTH + 2);

    logic last_winner_q, last_winner_d;
    logic resp_valid_q, resp_valid_d;
    logic resp_owner_q, resp_owner_d;
    logic resp_err_q, resp_err_d;
    logic resp_is_read_q, resp_is_read_d;

    logic                      gnt_instr, gnt_data, gnt_any;
    logic [SOC_ADDR_WIDTH-1:0] sel_addr, offset;
    logic                      in_range;
    logic                      wr_access;
    logic                      rd_ok;

    always_comb begin
        // On a tie the port that did not win last goes; reset holds everything off.
        gnt_data  = rst_ni & data_req_i & (~instr_req_i | (last_winner_q == OWNER_INSTR));
        gnt_instr = rst_ni & instr_req_i & ~gnt_data;
        gnt_any   = gnt_instr | gnt_data;
        sel_addr  = gnt_data ? data_addr_i : instr_addr_i;
        offset    = sel_addr - RAM_BASE;
        in_range  = {1'b0, offset} < RAM_BYTES;
        wr_access = gnt_data & data_we_i;

        instr_gnt_o = gnt_instr;
        data_gnt_o  = gnt_data;
        ram_en_o    = gnt_any & in_range;
        ram_we_o    = wr_access;
        ram_addr_o  = rst_ni ? offset[RAM_ADDR_WIDTH+1:2] : '0;
        ram_be_o    = !rst_ni ? 4'h0 : (wr_access ? data_be_i : 4'hF);
        ram_wdata_o = rst_ni ? data_wdata_i : 32'h0;

        last_winner_d  = gnt_any ? gnt_data : last_winner_q;
        resp_valid_d   = gnt_any;
        resp_owner_d   = gnt_data ? OWNER_DATA : OWNER_INSTR;
        resp_err_d     = gnt_any & ~in_range;
        resp_is_read_d = gnt_any & ~wr_access;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_winner_q  <= OWNER_INSTR;
            resp_valid_q   <= 1'b0;
            resp_owner_q   <= OWNER_INSTR;
            resp_err_q     <= 1'b0;
            resp_is_read_q <= 1'b0;
        end else begin
            last_winner_q  <= last_winner_d;
            resp_valid_q   <= resp_valid_d;
            resp_owner_q   <= resp_owner_d;
            resp_err_q     <= resp_err_d;
            resp_is_read_q <= resp_is_read_d;
        end
    end

    // RAM read data lands in the response cycle, so it is steered through combinationally.
    always_comb begin
        rd_ok          = resp_valid_q & resp_is_read_q & ~resp_err_q;
        instr_rvalid_o = resp_valid_q & (resp_owner_q == OWNER_INSTR);
        data_rvalid_o  = resp_valid_q & (resp_owner_q == OWNER_DATA);
        instr_err_o    = instr_rvalid_o & resp_err_q;
        data_err_o     = data_rvalid_o & resp_err_q;
        instr_rdata_o  = (instr_rvalid_o & rd_ok) ? ram_rdata_i : 32'h0;
        data_rdata_o   = (data_rvalid_o & rd_ok) ? ram_rdata_i : 32'h0;
    end

endmodule

// File: tb/tb_obi_sram_bridge.sv
// Bench for obi_sram_bridge: directed scenarios plus random traffic, compared each cycle
// against a transaction-level model (golden memory + pending-response record).
module tb_obi_sram_bridge;

    localparam int AW = 32;
    localparam int RW = 10;
    localparam logic [31:0] BASE = 32'h0;
    localparam longint RAM_BYTES = 4 * (1 << RW);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic instr_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
    logic [31:0] instr_addr = '0, data_addr = '0, data_wdata = '0;
    logic [3:0] data_be = '0;
    logic instr_gnt, data_gnt, instr_rvalid, data_rvalid, instr_err, data_err;
    logic [31:0] instr_rdata, data_rdata;
    logic ram_en, ram_we;
    logic [RW-1:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata = '0;
    logic [3:0] ram_be;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem  [0:1023];
    logic [31:0] gmem [0:1023];

    // model state
    bit          m_last_data;
    bit          m_pv, m_pdata, m_perr, m_prd;
    logic [31:0] m_pdat;

    always #5 clk = ~clk;

    obi_sram_bridge #(.SOC_ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RW), .RAM_BASE(BASE)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_addr_i(instr_addr),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
        .data_req_i(data_req), .data_gnt_o(data_gnt), .data_addr_i(data_addr),
        .data_we_i(data_we), .data_be_i(data_be), .data_wdata_i(data_wdata),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata), .data_err_o(data_err),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_rdata_i(ram_rdata)
    );

    // Single-port RAM with 1-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle reference model and comparison
    always @(negedge clk) begin
        bit gi, gd, inr, rd;
        logic [31:0] a, off;
        int wd;
        if (!rst_n) begin
            chk("rst_instr_gnt", {31'b0, instr_gnt}, 0);
            chk("rst_data_gnt", {31'b0, data_gnt}, 0);
            chk("rst_ram_en", {31'b0, ram_en}, 0);
            chk("rst_ram_we", {31'b0, ram_we}, 0);
            chk("rst_instr_rvalid", {31'b0, instr_rvalid}, 0);
            chk("rst_data_rvalid", {31'b0, data_rvalid}, 0);
            chk("rst_instr_rdata", instr_rdata, 0);
            chk("rst_data_rdata", data_rdata, 0);
            chk("rst_errs", {30'b0, instr_err, data_err}, 0);
            m_last_data = 0;
            m_pv = 0;
        end else begin
            gd  = data_req && (!instr_req || !m_last_data);
            gi  = instr_req && !gd;
            a   = gd ? data_addr : instr_addr;
            off = a - BASE;
            inr = longint'(off) < RAM_BYTES;
            wd  = int'(off[RW+1:2]);
            rd  = gi || (gd && !data_we);
            chk("instr_gnt", {31'b0, instr_gnt}, {31'b0, gi});
            chk("data_gnt", {31'b0, data_gnt}, {31'b0, gd});
            chk("ram_en", {31'b0, ram_en}, {31'b0, (gi || gd) && inr});
            chk("ram_we", {31'b0, ram_we}, {31'b0, gd && data_we});
            chk("ram_be", {28'b0, ram_be}, {28'b0, (gd && data_we) ? data_be : 4'hF});
            if (gi || gd) chk("ram_addr", {22'b0, ram_addr}, wd);
            if (gd && data_we) chk("ram_wdata", ram_wdata, data_wdata);
            chk("instr_rvalid", {31'b0, instr_rvalid}, {31'b0, m_pv && !m_pdata});
            chk("data_rvalid", {31'b0, data_rvalid}, {31'b0, m_pv && m_pdata});
            chk("instr_err", {31'b0, instr_err}, {31'b0, m_pv && !m_pdata && m_perr});
            chk("data_err", {31'b0, data_err}, {31'b0, m_pv && m_pdata && m_perr});
            chk("instr_rdata", instr_rdata,
                (m_pv && !m_pdata && m_prd && !m_perr) ? m_pdat : 32'h0);
            chk("data_rdata", data_rdata,
                (m_pv && m_pdata && m_prd && !m_perr) ? m_pdat : 32'h0);
            // advance: this cycle's grant becomes next cycle's response
            m_pv    = gi || gd;
            m_pdata = gd;
            m_perr  = !inr;
            m_prd   = rd;
            m_pdat  = inr ? gmem[wd] : 32'h0;
            if (gd && data_we && inr)
                for (int b = 0; b < 4; b++)
                    if (data_be[b]) gmem[wd][b*8 +: 8] = data_wdata[b*8 +: 8];
            if (gi || gd) m_last_data = gd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_req = 0; data_req = 0; data_we = 0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 0;
        idle();
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] v;
            v = $urandom;
            mem[i] = v;
            gmem[i] = v;
        end
        mem[0] = 32'h1111_1111; gmem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222; gmem[1] = 32'h2222_2222;
        mem[2] = 32'hDEAD_BEEF; gmem[2] = 32'hDEAD_BEEF;
        repeat (3) step();
        rst_n = 1;

        // 1: instr read of word 2
        step();
        instr_req = 1; instr_addr = 32'h8;
        @(negedge clk);
        chk("t1_gnt", {31'b0, instr_gnt}, 1);
        chk("t1_ram_addr", {22'b0, ram_addr}, 2);
        step(); idle();
        @(negedge clk);
        chk("t1_rvalid", {31'b0, instr_rvalid}, 1);
        chk("t1_rdata", instr_rdata, 32'hDEAD_BEEF);
        chk("t1_err", {31'b0, instr_err}, 0);

        // 2: data write
        step();
        data_req = 1; data_we = 1; data_addr = 32'h10; data_be = 4'b0011;
        data_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("t2_en_we", {30'b0, ram_en, ram_we}, 3);
        chk("t2_be", {28'b0, ram_be}, 4'b0011);
        chk("t2_addr", {22'b0, ram_addr}, 4);
        step(); idle();
        @(negedge clk);
        chk("t2_rvalid", {31'b0, data_rvalid}, 1);
        chk("t2_rdata", data_rdata, 0);

        // 3: tie held 4 cycles after reset
        do_reset();
        instr_req = 1; instr_addr = 32'h4;
        data_req = 1; data_we = 0; data_addr = 32'h8;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_data_gnt", {31'b0, data_gnt}, (k % 2 == 0) ? 1 : 0);
            chk("t3_instr_gnt", {31'b0, instr_gnt}, (k % 2 == 1) ? 1 : 0);
            if (k > 0) chk("t3_data_rvalid", {31'b0, data_rvalid}, (k % 2 == 1) ? 1 : 0);
        end
        step(); idle();

        // 4: out-of-range data read
        step();
        data_req = 1; data_we = 0; data_addr = BASE + 32'h1000;
        @(negedge clk);
        chk("t4_gnt", {31'b0, data_gnt}, 1);
        chk("t4_en", {31'b0, ram_en}, 0);
        step(); idle();
        @(negedge clk);
        chk("t4_rvalid_err", {30'b0, data_rvalid, data_err}, 3);
        chk("t4_rdata", data_rdata, 0);

        // 5: back-to-back reads of words 0,1,2
        step();
        data_req = 1; data_we = 0; data_addr = 32'h0;
        @(negedge clk);
        step(); data_addr = 32'h4;
        @(negedge clk);
        chk("t5_rdata0", data_rvalid ? data_rdata : 32'hFFFF_FFFF, 32'h1111_1111);
        step(); data_addr = 32'h8;
        @(negedge clk);
        chk("t5_rdata1", data_rvalid ? data_rdata : 32'hFFFF_FFFF, 32'h2222_2222);
        step(); idle();
        @(negedge clk);
        chk("t5_rdata2", data_rvalid ? data_rdata : 32'hFFFF_FFFF, 32'hDEAD_BEEF);

        // 6: reset the cycle after a grant
        step();
        instr_req = 1; instr_addr = 32'h20;
        @(negedge clk);
        chk("t6_gnt", {31'b0, instr_gnt}, 1);
        step(); rst_n = 0; idle();
        @(negedge clk);
        chk("t6_no_rvalid", {30'b0, instr_rvalid, data_rvalid}, 0);
        step(); step(); rst_n = 1;
        @(negedge clk);
        chk("t6_post_outs", {29'b0, instr_rvalid, data_rvalid, ram_en}, 0);
        step();
        instr_req = 1; data_req = 1; data_we = 0; instr_addr = 32'h0; data_addr = 32'h4;
        @(negedge clk);
        chk("t6_tie_data", {30'b0, data_gnt, instr_gnt}, 2);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 0; idle();
                step();
                rst_n = 1;
            end
            instr_req  = ($urandom_range(0, 2) != 0);
            data_req   = ($urandom_range(0, 2) != 0);
            data_we    = $urandom_range(0, 1);
            data_be    = 4'($urandom);
            data_wdata = $urandom;
            instr_addr = ($urandom_range(0, 9) < 8) ? BASE + {20'b0, 10'($urandom), 2'($urandom)} : $urandom;
            data_addr  = ($urandom_range(0, 9) < 8) ? BASE + {20'b0, 10'($urandom), 2'($urandom)} : $urandom;
        end
        step(); idle();
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
